wbs_node_table: RTL and testbench
=================================

# wbs_node_table

Wishbone-slave KD-tree internal-node table sitting between the user-project Wishbone bus and the traversal datapath. Decodes accesses in the node window (base 0x3004_0000), unpacks each 32-bit write into an 11-bit split-dimension index and 11-bit median, stores it by heap position (root = 1), and tracks load completion. The traversal logic reads the table through an independent combinational port. Wishbone reads return the stored word for host-side verification.

## Interface
- DATA_WIDTH, 11, width of index and median fields
- NUM_NODES, 63, internal nodes (heap positions 1..NUM_NODES)
- ADDR_WIDTH, 6, $clog2(NUM_NODES+1), node address width
- BASE_ADDR, 32'h3004_0000, window base
- ADDR_MASK, 32'hFFFF_0000, window decode mask

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe/cycle/write
- wbs_sel_i  in  4  ignored; all accesses are full-word
- wbs_adr_i  in  32  byte address; offset = wbs_adr_i[15:0]
- wbs_dat_i  in  32  [10:0] index, [21:11] median, [31:22] ignored
- wbs_ack_o  out  1  registered one-cycle acknowledge
- wbs_dat_o  out  32  read data {10'b0, median, index}; 0 when not acking
- load_en  in  1  mode bit; writes commit only when high
- clear  in  1  synchronous clear of valid bitmap, count, err
- rd_addr  in  ADDR_WIDTH  traversal read address (heap position)
- rd_index, rd_median  out  DATA_WIDTH  combinational table read
- node_count  out  ADDR_WIDTH  number of distinct nodes written
- nodes_loaded  out  1  high when node_count == NUM_NODES
- err  out  1  sticky: out-of-range access seen

## Operation
- Hit = cyc & stb & ((adr & ADDR_MASK) == BASE_ADDR). Non-hits: no ack, no state change.
- In-range = 1 <= offset <= NUM_NODES. Entry 0 does not exist; rd_addr 0 or > NUM_NODES returns 0.
- FSM IDLE/ACK. IDLE + hit: commit access, ack_o<=1, dat_o<=result, go ACK. ACK: ack_o<=0, dat_o<=0, go IDLE unconditionally (one turnaround cycle; a still-asserted strobe is serviced as a new access from IDLE).
- Write, in-range, load_en=1: table[offset] <= {median, index}; if valid[offset]==0, set it and node_count++. Rewrites update data and leave count unchanged.
- Write with load_en=0: acked, nothing stored, no error.
- Read, in-range: returns stored word (0 if never written), regardless of load_en.
- Out-of-range hit (either direction): acked, no write, read data 0, err<=1.
- clear: valid bitmap, node_count, err <= 0 on the next edge; table data retained. A hit in the same cycle is acked but its write is dropped (clear wins); a read still returns table data.
- rd_* is combinational from the table; a write committed at edge N is visible on rd_* after edge N.

## Timing
- Reset (async assert, sync release internally not required): state IDLE, wbs_ack_o=0, wbs_dat_o=0, table all 0, valid 0, node_count=0, nodes_loaded=0, err=0. Reset mid-ACK drops ack immediately.
- Latency: request sampled at edge N; ack_o and dat_o high/valid for exactly cycle N..N+1; earliest next acceptance at edge N+2.
- Maximum throughput one access per 2 cycles.
- nodes_loaded and node_count update at the same edge as the committing write.
- node_count saturates at NUM_NODES by construction (bitmap-gated).

## Test plan
- Reset, load_en=1, write 0x3004_0001 data {median=55, index=1} -> ack one cycle later, pulse width 1; rd_addr=1 gives 1/55; node_count=1; read-back same address returns 0x0001_B801.
- Write all heap positions 1..63 with distinct data, one rewrite of position 5 -> node_count=63, nodes_loaded=1 only after last new position; rewrite leaves count at 63; all 63 read back correctly.
- Hold stb/cyc high across write-then-read (we_i dropped after ack) -> two acks separated by one idle cycle; read returns written word.
- Access 0x3004_0000 and 0x3004_0040 -> acked, no table change, read data 0, err=1; access 0x3003_0001 -> no ack, table untouched.
- load_en=0 write -> acked, count unchanged; clear asserted with simultaneous write -> count=0, err=0, write dropped.
- Assert rst_n low during ACK -> ack_o falls immediately; after release table reads 0 and node_count=0.

Source files
------------

// File: rtl/wbs_node_table.sv
// rtl/wbs_node_table.sv - Wishbone-loaded KD-tree internal-node table with combinational traversal read port
module wbs_node_table #(
  parameter int          DATA_WIDTH = 11,
  parameter int          NUM_NODES  = 63,
  parameter int          ADDR_WIDTH = $clog2(NUM_NODES + 1),
  parameter logic [31:0] BASE_ADDR  = 32'h3004_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic                  load_en,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_median,
  output logic [ADDR_WIDTH-1:0] node_count,
  output logic                  nodes_loaded,
  output logic                  err
);

  localparam int                    ENTRY_W  = 2 * DATA_WIDTH;
  localparam logic [15:0]           MAX_OFF  = 16'(NUM_NODES);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(NUM_NODES);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t state_q, state_d;

  // Heap position p lives in entry p-1; position 0 has no storage.
  logic [ENTRY_W-1:0]    tbl [NUM_NODES];
  logic [NUM_NODES-1:0]  valid_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  err_q;

  logic                  ack_d;
  logic [31:0]           dat_d;

  logic [15:0]           offset;
  logic                  hit;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic                  commit;

  logic                  rd_ok;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ENTRY_W-1:0]    rd_entry;

  logic                  unused_bits;

  assign offset   = wbs_adr_i[15:0];
  assign hit      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign in_range = (offset != 16'd0) && (offset <= MAX_OFF);
  assign idx      = offset[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign accept   = (state_q == S_IDLE) && hit;
  // Clear takes priority over a same-cycle write.
  assign commit   = accept && wbs_we_i && in_range && load_en && !clear;

  assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:ENTRY_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d = 1'b0;
    dat_d = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          ack_d = 1'b1;
          if (!wbs_we_i && in_range) begin
            dat_d = 32'(tbl[idx]);
          end
        end
      end
      default: begin
        ack_d = 1'b0;
        dat_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= ack_d;
      wbs_dat_o <= dat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        tbl[i] <= '0;
      end
    end else if (commit) begin
      tbl[idx] <= wbs_dat_i[ENTRY_W-1:0];
    end
  end

  // Count only first writes so the count can never exceed NUM_NODES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (commit && !valid_q[idx]) begin
        valid_q[idx] <= 1'b1;
        count_q      <= count_q + ADDR_WIDTH'(1);
      end
      if (accept && !in_range) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rd_ok    = (rd_addr != '0) && (rd_addr <= MAX_ADDR);
  assign rd_idx   = rd_addr - ADDR_WIDTH'(1);
  assign rd_entry = rd_ok ? tbl[rd_idx] : '0;

  assign rd_index     = rd_entry[DATA_WIDTH-1:0];
  assign rd_median    = rd_entry[ENTRY_W-1:DATA_WIDTH];
  assign node_count   = count_q;
  assign nodes_loaded = (count_q == MAX_ADDR);
  assign err          = err_q;

endmodule

// File: tb/tb_wbs_node_table.sv
// tb/tb_wbs_node_table.sv - scoreboard bench for wbs_node_table
module tb_wbs_node_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        load_en, clear;
  logic [5:0]  rd_addr;
  logic [10:0] rd_index, rd_median;
  logic [5:0]  node_count;
  logic        nodes_loaded, err;

  wbs_node_table dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .load_en(load_en), .clear(clear), .rd_addr(rd_addr),
    .rd_index(rd_index), .rd_median(rd_median),
    .node_count(node_count), .nodes_loaded(nodes_loaded), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  logic [21:0] m_tbl [64];
  bit          m_valid [64];
  int          m_count;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_tbl[i]   = '0;
      m_valid[i] = 1'b0;
    end
    m_count = 0;
    m_err   = 1'b0;
  endfunction

  // Single access: request at a negedge, ack expected after the next edge, gone one edge later.
  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat, input bit with_clear);
    bit   hit;
    bit   inr;
    int   off;
    exp_t e;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  clear = with_clear;
    hit = ((adr & 32'hFFFF_0000) == 32'h3004_0000);
    off = int'(adr[15:0]);
    inr = (off >= 1) && (off <= 63);
    if (hit) begin
      e.chk_dat = !we;
      e.dat     = (!we && inr) ? 32'(m_tbl[off]) : 32'd0;
      sb.push_back(e);
      if (inr && we && load_en && !with_clear) begin
        m_tbl[off] = dat[21:0];
        if (!m_valid[off]) begin
          m_valid[off] = 1'b1;
          m_count++;
        end
      end
      if (!inr) m_err = 1'b1;
    end
    if (with_clear) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      m_count = 0;
      m_err   = 1'b0;
    end
    @(negedge clk);
    chk("ack_rise", 32'(wbs_ack_o), 32'(hit));
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("ack_fall", 32'(wbs_ack_o), 32'd0);
  endtask

  task automatic check_rd(input int a);
    rd_addr = 6'(a);
    #1;
    chk("rd_index", 32'(rd_index), (a >= 1 && a <= 63) ? 32'(m_tbl[a][10:0]) : 32'd0);
    chk("rd_median", 32'(rd_median), (a >= 1 && a <= 63) ? 32'(m_tbl[a][21:11]) : 32'd0);
  endtask

  task automatic check_status();
    chk("node_count", 32'(node_count), 32'(m_count));
    chk("nodes_loaded", 32'(nodes_loaded), 32'(m_count == 63));
    chk("err", 32'(err), 32'(m_err));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wbs_ack_o) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        if (e.chk_dat) chk("rd_data", wbs_dat_o, e.dat);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = '0; wbs_dat_i = '0;
    load_en = 1'b0; clear = 1'b0; rd_addr = 6'd1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    check_status();
    check_rd(1);
    rst_n = 1'b1;

    // First write and read-back
    load_en = 1'b1;
    wb_xfer(1'b1, 32'h3004_0001, 32'h0001_B801, 1'b0);
    check_rd(1);
    check_status();
    wb_xfer(1'b0, 32'h3004_0001, 32'd0, 1'b0);

    // Fill every heap position; nodes_loaded only after the last new one
    for (int i = 1; i <= 63; i++) begin
      wb_xfer(1'b1, 32'h3004_0000 | 32'(i),
              {10'h3FF, 11'(i * 13 + 100), 11'(i + 500)}, 1'b0);
      if (i == 62 || i == 63) check_status();
    end
    wb_xfer(1'b1, 32'h3004_0005, 32'h0012_3456, 1'b0);
    check_status();
    for (int i = 1; i <= 63; i++) begin
      wb_xfer(1'b0, 32'h3004_0000 | 32'(i), 32'd0, 1'b0);
      check_rd(i);
    end
    check_rd(0);

    // Strobe held across write then read: two acks with one idle cycle between
    begin
      exp_t e;
      @(negedge clk);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = 32'h3004_000A; wbs_dat_i = 32'h002A_BCDE;
      e.chk_dat = 1'b0; e.dat = 32'd0;
      sb.push_back(e);
      m_tbl[10] = wbs_dat_i[21:0];
      @(negedge clk);
      chk("hold_ack1", 32'(wbs_ack_o), 32'd1);
      wbs_we_i = 1'b0;
      e.chk_dat = 1'b1; e.dat = 32'(m_tbl[10]);
      sb.push_back(e);
      @(negedge clk);
      chk("hold_gap", 32'(wbs_ack_o), 32'd0);
      @(negedge clk);
      chk("hold_ack2", 32'(wbs_ack_o), 32'd1);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(negedge clk);
      chk("hold_fall", 32'(wbs_ack_o), 32'd0);
      check_rd(10);
    end

    // Out-of-range offsets and a miss outside the window
    wb_xfer(1'b1, 32'h3004_0000, 32'h0000_0777, 1'b0);
    check_status();
    wb_xfer(1'b0, 32'h3004_0040, 32'd0, 1'b0);
    wb_xfer(1'b0, 32'h3004_0000, 32'd0, 1'b0);
    wb_xfer(1'b1, 32'h3003_0001, 32'h0000_0111, 1'b0);
    check_rd(1);
    check_status();

    // load_en low drops the write; clear beats a simultaneous write
    load_en = 1'b0;
    wb_xfer(1'b1, 32'h3004_0003, 32'h0000_0333, 1'b0);
    check_rd(3);
    check_status();
    load_en = 1'b1;
    wb_xfer(1'b1, 32'h3004_0004, 32'h0000_0444, 1'b1);
    check_rd(4);
    check_status();
    wb_xfer(1'b0, 32'h3004_0004, 32'd0, 1'b0);
    wb_xfer(1'b1, 32'h3004_0007, 32'h0000_0707, 1'b0);
    check_status();

    // Reset during ACK drops ack immediately and empties the table
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3004_0008; wbs_dat_i = 32'h0000_0808;
    @(posedge clk);
    #2;
    chk("pre_rst_ack", 32'(wbs_ack_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(wbs_ack_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_rd(7);
    check_rd(8);
    check_rd(1);
    check_status();

    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
